cmd_mode_ctrl: RTL and testbench

//  Parametrised command/data splitter for the received-character byte stream.

---
 rtl/cmd_mode_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_cmd_mode_ctrl.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cmd_mode_ctrl.sv
// Splits the received byte stream into data bytes for the write side and M..F / C command frames.
// Latency 1 (all outputs registered); o_wren holds until i_wr_ready, and a data byte that cannot be loaded is dropped with o_overflow.
module cmd_mode_ctrl #(
    parameter int DATA_W       = 8,
    parameter int RATE_W       = 2,
    parameter int RATE_DEFAULT = 0,
    parameter int TIMEOUT_CYC  = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_valid,
    input  logic [DATA_W-1:0] i_data,
    output logic [DATA_W-1:0] o_data,
    output logic              o_wren,
    input  logic              i_wr_ready,
    output logic [RATE_W-1:0] o_rate,
    output logic              o_clean,
    output logic              o_finish,
    output logic              o_timeout,
    output logic              o_overflow,
    output logic              o_ctrl_active
);

    localparam int                TMR_W    = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam logic [RATE_W-1:0] RATE_RST = RATE_W'(RATE_DEFAULT);
    localparam logic [RATE_W-1:0] RATE_ONE = RATE_W'(1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_CTRL = 1'b1
    } state_t;

    state_t              r_state;
    logic [RATE_W-1:0]   r_rate;
    logic [RATE_W-1:0]   r_pending;
    logic [TMR_W-1:0]    r_timer;
    logic [DATA_W-1:0]   r_data;
    logic                r_wren;
    logic                r_clean;
    logic                r_finish;
    logic                r_timeout;
    logic                r_overflow;

    state_t              w_state_nxt;
    logic [RATE_W-1:0]   w_rate_nxt;
    logic [RATE_W-1:0]   w_pending_nxt;
    logic [TMR_W-1:0]    w_timer_nxt;
    logic [DATA_W-1:0]   w_data_nxt;
    logic                w_wren_nxt;
    logic                w_clean_nxt;
    logic                w_finish_nxt;
    logic                w_timeout_nxt;
    logic                w_overflow_nxt;

    logic [7:0]          w_chr;
    logic [7:0]          w_fold;
    logic                w_hi_zero;
    logic                w_byte;
    logic                w_is_m;
    logic                w_is_f;
    logic                w_is_c;
    logic                w_is_a;
    logic                w_is_1;
    logic                w_is_5;
    logic                w_can_load;
    logic                w_tmr_hit;

    // Command codes live in the low byte; any set upper bit makes the byte plain data.
    assign w_chr      = i_data[7:0];
    assign w_fold     = w_chr | 8'h20;
    assign w_hi_zero  = ((i_data >> 8) == '0);
    assign w_byte     = i_valid && (i_data != '0);
    assign w_is_m     = w_hi_zero && (w_fold == 8'h6D);
    assign w_is_f     = w_hi_zero && (w_fold == 8'h66);
    assign w_is_c     = w_hi_zero && (w_fold == 8'h63);
    assign w_is_a     = w_hi_zero && (w_fold == 8'h61);
    assign w_is_1     = w_hi_zero && (w_chr == 8'h31);
    assign w_is_5     = w_hi_zero && (w_chr == 8'h35);
    assign w_can_load = !r_wren || i_wr_ready;

    // Fires on the idle cycle that brings the timer to TIMEOUT_CYC-1.
    assign w_tmr_hit = (TIMEOUT_CYC != 0) && ((int'(r_timer) + 1) >= (TIMEOUT_CYC - 1));

    always_comb begin
        w_state_nxt    = r_state;
        w_rate_nxt     = r_rate;
        w_pending_nxt  = r_pending;
        w_timer_nxt    = r_timer;
        w_data_nxt     = r_data;
        w_wren_nxt     = r_wren && !i_wr_ready;
        w_clean_nxt    = 1'b0;
        w_finish_nxt   = 1'b0;
        w_timeout_nxt  = 1'b0;
        w_overflow_nxt = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_timer_nxt = '0;
                if (w_byte) begin
                    if (w_is_m) begin
                        w_state_nxt   = ST_CTRL;
                        w_pending_nxt = r_rate;
                    end else if (w_is_c) begin
                        w_clean_nxt = 1'b1;
                        w_rate_nxt  = RATE_RST;
                    end else if (w_is_f) begin
                        w_state_nxt = ST_IDLE;
                    end else if (w_can_load) begin
                        w_data_nxt = i_data;
                        w_wren_nxt = 1'b1;
                    end else begin
                        w_overflow_nxt = 1'b1;
                    end
                end
            end
            ST_CTRL: begin
                if (w_byte) begin
                    w_timer_nxt = '0;
                    if (w_is_1) begin
                        w_pending_nxt = '0;
                    end else if (w_is_5) begin
                        w_pending_nxt = RATE_ONE;
                    end else if (w_is_a) begin
                        w_pending_nxt = '1;
                    end else if (w_is_m) begin
                        w_pending_nxt = r_rate;
                    end else if (w_is_f) begin
                        w_rate_nxt   = r_pending;
                        w_finish_nxt = 1'b1;
                        w_state_nxt  = ST_IDLE;
                    end else if (w_is_c) begin
                        w_state_nxt = ST_IDLE;
                    end
                end else if (w_tmr_hit) begin
                    w_timeout_nxt = 1'b1;
                    w_timer_nxt   = '0;
                    w_state_nxt   = ST_IDLE;
                end else if (TIMEOUT_CYC != 0) begin
                    w_timer_nxt = r_timer + TMR_W'(1);
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= ST_IDLE;
            r_rate     <= RATE_RST;
            r_pending  <= RATE_RST;
            r_timer    <= '0;
            r_data     <= '0;
            r_wren     <= 1'b0;
            r_clean    <= 1'b0;
            r_finish   <= 1'b0;
            r_timeout  <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_rate     <= w_rate_nxt;
            r_pending  <= w_pending_nxt;
            r_timer    <= w_timer_nxt;
            r_data     <= w_data_nxt;
            r_wren     <= w_wren_nxt;
            r_clean    <= w_clean_nxt;
            r_finish   <= w_finish_nxt;
            r_timeout  <= w_timeout_nxt;
            r_overflow <= w_overflow_nxt;
        end
    end

    assign o_data        = r_data;
    assign o_wren        = r_wren;
    assign o_rate        = r_rate;
    assign o_clean       = r_clean;
    assign o_finish      = r_finish;
    assign o_timeout     = r_timeout;
    assign o_overflow    = r_overflow;
    assign o_ctrl_active = (r_state == ST_CTRL);

endmodule

// File: tb/tb_cmd_mode_ctrl.sv
// Bench for cmd_mode_ctrl: directed scenarios plus randomized traffic against a behavioural model.
// Outputs are checked 1 ns after each rising edge.
module tb_cmd_mode_ctrl;

    localparam int TMO = 16;

    logic       clk;
    logic       rst_n;
    logic       i_valid;
    logic [7:0] i_data;
    logic [7:0] o_data;
    logic       o_wren;
    logic       i_wr_ready;
    logic [1:0] o_rate;
    logic       o_clean;
    logic       o_finish;
    logic       o_timeout;
    logic       o_overflow;
    logic       o_ctrl_active;

    int n_chk  = 0;
    int n_fail = 0;

    cmd_mode_ctrl #(
        .DATA_W       (8),
        .RATE_W       (2),
        .RATE_DEFAULT (0),
        .TIMEOUT_CYC  (TMO)
    ) dut (
        .clk           (clk),
        .reset         (rst_n),
        .i_valid       (i_valid),
        .i_data        (i_data),
        .o_data        (o_data),
        .o_wren        (o_wren),
        .i_wr_ready    (i_wr_ready),
        .o_rate        (o_rate),
        .o_clean       (o_clean),
        .o_finish      (o_finish),
        .o_timeout     (o_timeout),
        .o_overflow    (o_overflow),
        .o_ctrl_active (o_ctrl_active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state: what the block should be showing after each edge.
    bit         m_ctrl;
    int         m_rate;
    int         m_pend;
    int         m_idle;
    logic [7:0] m_data;
    bit         m_wren;
    bit         m_clean;
    bit         m_finish;
    bit         m_tmo;
    bit         m_ovf;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [7:0] lc(input logic [7:0] d);
        return (d >= 8'h41 && d <= 8'h5A) ? d + 8'h20 : d;
    endfunction

    function automatic void model_reset();
        m_ctrl = 0; m_rate = 0; m_pend = 0; m_idle = 0;
        m_data = 8'h00; m_wren = 0;
        m_clean = 0; m_finish = 0; m_tmo = 0; m_ovf = 0;
    endfunction

    function automatic void model_step(input bit v, input logic [7:0] d, input bit rdy);
        bit         live;
        bit         loaded;
        logic [7:0] c;
        live   = v && (d != 8'h00);
        loaded = 0;
        c      = lc(d);
        m_clean = 0; m_finish = 0; m_tmo = 0; m_ovf = 0;
        if (!m_ctrl) begin
            if (live) begin
                if (c == "m") begin
                    m_ctrl = 1; m_pend = m_rate; m_idle = 0;
                end else if (c == "c") begin
                    m_clean = 1; m_rate = 0;
                end else if (c == "f") begin
                    m_clean = 0;
                end else if (!m_wren || rdy) begin
                    m_data = d; loaded = 1;
                end else begin
                    m_ovf = 1;
                end
            end
        end else begin
            if (live) begin
                m_idle = 0;
                if (c == "1")      m_pend = 0;
                else if (c == "5") m_pend = 1;
                else if (c == "a") m_pend = 3;
                else if (c == "m") m_pend = m_rate;
                else if (c == "f") begin m_rate = m_pend; m_finish = 1; m_ctrl = 0; end
                else if (c == "c") m_ctrl = 0;
            end else begin
                m_idle++;
                if (m_idle >= TMO - 1) begin
                    m_tmo = 1; m_ctrl = 0; m_idle = 0;
                end
            end
        end
        m_wren = loaded ? 1'b1 : (m_wren && !rdy);
    endfunction

    task automatic chk_all();
        chk("o_data",        o_data,        m_data);
        chk("o_wren",        o_wren,        m_wren);
        chk("o_rate",        o_rate,        m_rate);
        chk("o_clean",       o_clean,       m_clean);
        chk("o_finish",      o_finish,      m_finish);
        chk("o_timeout",     o_timeout,     m_tmo);
        chk("o_overflow",    o_overflow,    m_ovf);
        chk("o_ctrl_active", o_ctrl_active, m_ctrl);
    endtask

    task automatic cyc(input bit v, input logic [7:0] d, input bit rdy);
        i_valid    = v;
        i_data     = d;
        i_wr_ready = rdy;
        @(posedge clk);
        model_step(v, d, rdy);
        #1;
        chk_all();
    endtask

    // Called 1 ns after a rising edge; reset lands mid-cycle, asynchronously.
    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk_all();
        i_valid    = 1'b0;
        i_wr_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        cyc(0, 8'h00, 0);
    endtask

    task automatic send(input string s, input bit rdy);
        for (int k = 0; k < s.len(); k++) cyc(1, s[k], rdy);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int         tmo_at;
        bit         v;
        bit         rdy;
        logic [7:0] d;
        int         pick;

        rst_n = 1'b0; i_valid = 1'b0; i_data = 8'h00; i_wr_ready = 1'b0;
        #12;
        model_reset();
        chk_all();
        @(negedge clk);
        rst_n = 1'b1;
        cyc(0, 8'h00, 1);

        // Data passes through with ready high.
        cyc(1, "h", 1);
        chk("t1_data_h", o_data, 8'h68);
        cyc(1, "i", 1);
        chk("t1_data_i", o_data, 8'h69);
        cyc(0, 8'h00, 1);
        chk("t1_wren_off", o_wren, 1'b0);

        // Back-pressure: second byte dropped, first held until ready.
        cyc(1, "x", 0);
        cyc(1, "y", 0);
        chk("t2_ovf", o_overflow, 1'b1);
        chk("t2_held", o_data, 8'h78);
        cyc(0, 8'h00, 1);
        cyc(0, 8'h00, 1);
        chk("t2_drained", o_wren, 1'b0);

        // Rate frames commit only on F.
        send("M5", 1);
        chk("t3_rate_staged", o_rate, 2'd0);
        cyc(1, "F", 1);
        chk("t3_rate_1", o_rate, 2'd1);
        chk("t3_finish", o_finish, 1'b1);
        send("maf", 1);
        chk("t3_rate_3", o_rate, 2'd3);

        // Control-mode timeout.
        send("MA", 1);
        tmo_at = -1;
        for (int k = 1; k <= 40; k++) begin
            cyc(0, 8'h00, 1);
            if (o_timeout && tmo_at < 0) tmo_at = k;
        end
        chk("t4_tmo_latency", tmo_at, 15);
        chk("t4_rate_kept", o_rate, 2'd3);
        chk("t4_idle", o_ctrl_active, 1'b0);

        // Clean in IDLE versus abort in CTRL.
        cyc(1, "C", 1);
        chk("t5_clean", o_clean, 1'b1);
        chk("t5_rate_def", o_rate, 2'd0);
        send("M1c", 1);
        chk("t5_no_clean", o_clean, 1'b0);
        chk("t5_idle", o_ctrl_active, 1'b0);

        // Reset mid-frame discards the pending rate.
        send("M5", 1);
        do_reset();
        cyc(1, "F", 1);
        chk("t6_rate", o_rate, 2'd0);
        chk("t6_finish", o_finish, 1'b0);

        // Randomized traffic.
        for (int it = 0; it < 2500; it++) begin
            rdy = ($urandom_range(0, 99) < 70);
            if ($urandom_range(0, 149) == 0) begin
                for (int g = 0; g < 20; g++) cyc(0, 8'($urandom), ($urandom_range(0, 1) == 1));
            end else if ($urandom_range(0, 799) == 0) begin
                do_reset();
            end else begin
                v    = ($urandom_range(0, 99) < 65);
                pick = $urandom_range(0, 15);
                case (pick)
                    0:  d = "M";
                    1:  d = "m";
                    2:  d = "F";
                    3:  d = "f";
                    4:  d = "C";
                    5:  d = "c";
                    6:  d = "A";
                    7:  d = "a";
                    8:  d = "1";
                    9:  d = "5";
                    10: d = m_ctrl ? 8'($urandom_range(32, 126)) : 8'h00;
                    11: d = 8'($urandom_range(1, 255));
                    default: d = 8'($urandom_range(32, 126));
                endcase
                cyc(v, d, rdy);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
